// File: rtl/thumb_fetch_pkg.sv
// thumb_fetch_pkg
// Shared types and widths for the Thumb fetch stage: fetch FSM states,
// halfword/word widths, instruction memory address width and the helper
// that advances the fetch PC past the halfwords taken from one word.
package thumb_fetch_pkg;

  localparam int HWORD_W    = 16;
  localparam int WORD_W     = 32;
  localparam int MEM_AWIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  // An odd-halfword PC only consumes the upper half of its word, so it
  // advances by 2 to land on the next word boundary; aligned PCs take both.
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return pc + (pc[1] ? 32'd2 : 32'd4);
  endfunction

endpackage

// File: rtl/fetch_hw_fifo.sv
// fetch_hw_fifo
// DEPTH-entry FIFO of {pc, halfword} pairs feeding the decoder.
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   flush                   synchronous clear; wins over push and pop
//   push_cnt                number of entries written this cycle (0/1/2)
//   push_hw0/push_pc0       first entry written
//   push_hw1/push_pc1       second entry written when push_cnt == 2
//   pop                     consume the head (ignored when empty)
//   count                   occupied entries
//   head_valid/hw/pc        combinational view of the head slot
module fetch_hw_fifo
  import thumb_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [1:0]               push_cnt,
  input  logic [HWORD_W-1:0]       push_hw0,
  input  logic [31:0]              push_pc0,
  input  logic [HWORD_W-1:0]       push_hw1,
  input  logic [31:0]              push_pc1,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [HWORD_W-1:0]       head_hw,
  output logic [31:0]              head_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [HWORD_W-1:0] hw_mem [DEPTH];
  logic [31:0]        pc_mem [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic               do_pop;

  assign do_pop     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head_hw    = hw_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two. A flush keeps
  // the read pointer so the head outputs keep showing the old slot contents
  // while instr_valid is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hw_mem[i] <= '0;
        pc_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push_cnt != 2'd0) begin
        hw_mem[wr_ptr] <= push_hw0;
        pc_mem[wr_ptr] <= push_pc0;
      end
      if (push_cnt == 2'd2) begin
        hw_mem[wr_ptr + PW'(1)] <= push_hw1;
        pc_mem[wr_ptr + PW'(1)] <= push_pc1;
      end
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count  <= count + CW'(push_cnt) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/thumb_fetch_unit.sv
// thumb_fetch_unit
// Fetch/prefetch stage: reads 32-bit words from instruction memory, splits
// them into Thumb halfwords, buffers them and hands them to decode tagged
// with their byte address. Branch redirects flush the buffer and refetch.
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   mem_req/mem_addr        word read request, held until mem_ack
//   mem_ack/mem_rdata       read completion and returned word
//   redirect/redirect_pc    taken branch and its target byte address
//   instr_valid/instr/instr_pc   head halfword offered to decode
//   instr_ready             decode consumes the head this cycle
module thumb_fetch_unit
  import thumb_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  mem_req,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_W-1:0]     mem_rdata,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  output logic [HWORD_W-1:0]    instr,
  output logic [31:0]           instr_pc,
  input  logic                  instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t          state, state_next;
  logic [31:0]           fetch_pc, fetch_pc_next;
  logic [MEM_AWIDTH-1:0] drop_addr, drop_addr_next;
  logic [CW-1:0]         count;
  logic [CW:0]           count_after;
  logic                  pop;
  logic                  accept;
  logic                  room;
  logic [1:0]            push_cnt;
  logic                  unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc[0];

  assign pop    = instr_valid && instr_ready;
  assign accept = (state == FETCH) && mem_ack && !redirect;

  // An odd-halfword PC means the lower half of the word belongs to an
  // earlier instruction stream position, so only the upper half is kept.
  assign push_cnt = !accept ? 2'd0 : (fetch_pc[1] ? 2'd1 : 2'd2);

  // A new request needs two free slots measured after this cycle's push
  // and pop, which guarantees a returning word always fits.
  assign count_after = {1'b0, count} + (CW+1)'(push_cnt) - (CW+1)'(pop);
  assign room        = count_after <= (CW+1)'(DEPTH - 2);

  assign mem_req  = (state != IDLE);
  assign mem_addr = (state == DROP) ? drop_addr : fetch_pc[MEM_AWIDTH+1:2];

  fetch_hw_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect),
    .push_cnt   (push_cnt),
    .push_hw0   (fetch_pc[1] ? mem_rdata[31:16] : mem_rdata[15:0]),
    .push_pc0   (fetch_pc),
    .push_hw1   (mem_rdata[31:16]),
    .push_pc1   (fetch_pc + 32'd2),
    .pop        (pop),
    .count      (count),
    .head_valid (instr_valid),
    .head_hw    (instr),
    .head_pc    (instr_pc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      drop_addr <= drop_addr_next;
    end
  end

  // A redirect always retargets fetch_pc. An in-flight read that cannot be
  // cancelled moves to DROP, which keeps presenting the address the memory
  // already saw until it answers, then throws the data away.
  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    drop_addr_next = drop_addr;
    if (redirect) begin
      fetch_pc_next = {redirect_pc[31:1], 1'b0};
    end
    case (state)
      IDLE: begin
        if (!redirect && room) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          drop_addr_next = fetch_pc[MEM_AWIDTH+1:2];
          state_next     = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          fetch_pc_next = next_fetch_pc(fetch_pc);
          state_next    = room ? FETCH : IDLE;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_thumb_fetch_unit.sv
module tb_thumb_fetch_unit;
  import thumb_fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  thumb_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  // Free-running 10 ns clock; the bench drives and samples on the falling edge.
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  // Memory model state: one outstanding request with a chosen latency.
  bit          busy;
  int          wait_left;
  logic [9:0]  req_addr;
  int          lat_fixed;
  int          acks;
  logic [9:0]  req_log[$];

  // Decode-side model: the next byte address decode should see.
  logic [31:0] exp_pc;
  bit          redirect_last;
  int          consumed;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [9:0]  e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[9];

  // Instruction memory contents as a pure function of word address.
  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return ({22'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc[11:2]);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    n_checks++;
    n_fails++;
    $display("[TB] FAIL %s: bound expired, got no progress, expected progress", name);
  endtask

  // Assert reset, check the reset values asynchronously, then release on a
  // falling edge so the next cycle is the first one out of reset.
  task automatic do_reset();
    reset_n     = 1'b0;
    mem_ack     = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    #1;
    check_output("reset_mem_req", mem_req, 0);
    check_output("reset_mem_addr", mem_addr, {22'h0, RESET_PC[11:2]});
    check_output("reset_instr_valid", instr_valid, 0);
    check_output("reset_instr", instr, 0);
    check_output("reset_instr_pc", instr_pc, 0);
    busy          = 0;
    wait_left     = 0;
    acks          = 0;
    redirect_last = 0;
    exp_pc        = RESET_PC;
    req_log.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One cycle of the behavioural memory plus the decode scoreboard. Called
  // just after a falling edge and returns at the next falling edge.
  task automatic apply_stimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    if (redirect_last) check_output("valid_after_redirect", instr_valid, 0);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_req) begin
      if (!busy) begin
        busy      = 1;
        req_addr  = mem_addr;
        req_log.push_back(mem_addr);
        wait_left = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end else begin
        check_output("mem_addr_stable", mem_addr, req_addr);
      end
      if (wait_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        busy      = 0;
        acks++;
      end else begin
        wait_left--;
      end
    end else if (busy) begin
      check_output("mem_req_held", mem_req, 1);
      busy = 0;
    end
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (instr_valid && rdy) begin
      check_output("sb_instr_pc", instr_pc, exp_pc);
      check_output("sb_instr", instr, hw_at(exp_pc));
      exp_pc = exp_pc + 32'd2;
      consumed++;
    end
    if (redir) exp_pc = {rpc[31:1], 1'b0};
    redirect_last = redir;
    @(negedge clock);
  endtask

  initial begin
    int base;
    int stall;
    int last;
    bit done;

    consumed  = 0;
    lat_fixed = 0;
    @(negedge clock);

    // Directed table: zero-wait fetch of BEEF_2005, redirect to an odd
    // halfword, dropped in-flight word, and an upper-half-only push.
    vecs[0] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b0, 10'd0, 1'b0, 16'h0,    32'h0};
    vecs[1] = '{1'b1, 32'hBEEF_2005, 1'b0, 32'h0, 1'b1, 1'b1, 10'd0, 1'b0, 16'h0,    32'h0};
    vecs[2] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 10'd1, 1'b1, 16'h2005, 32'h0};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 32'h7, 1'b0, 1'b1, 10'd1, 1'b1, 16'hBEEF, 32'h2};
    vecs[4] = '{1'b1, 32'hDEAD_DEAD, 1'b0, 32'h0, 1'b1, 1'b1, 10'd1, 1'b0, 16'h0,    32'h0};
    vecs[5] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b0, 10'd1, 1'b0, 16'h0,    32'h0};
    vecs[6] = '{1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b1, 10'd1, 1'b0, 16'h0,    32'h0};
    vecs[7] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 10'd2, 1'b1, 16'h1234, 32'h6};
    vecs[8] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b1, 10'd2, 1'b0, 16'h0,    32'h0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      check_output($sformatf("tbl%0d_mem_req", i), mem_req, vecs[i].e_req);
      check_output($sformatf("tbl%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      check_output($sformatf("tbl%0d_instr_valid", i), instr_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        check_output($sformatf("tbl%0d_instr", i), instr, vecs[i].e_instr);
        check_output($sformatf("tbl%0d_instr_pc", i), instr_pc, vecs[i].e_pc);
      end
      mem_ack     = vecs[i].ack;
      mem_rdata   = vecs[i].rdata;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      instr_ready = vecs[i].rdy;
      @(negedge clock);
    end
    mem_ack  = 1'b0;
    redirect = 1'b0;

    // Backpressure: decode stalled, zero-wait memory fills the FIFO with
    // exactly two words; one pop is not enough room, a second pop is.
    $display("[TB] backpressure sequence");
    do_reset();
    lat_fixed = 0;
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 32'h0);
    check_output("bp_acks", acks, 2);
    check_output("bp_mem_req_low", mem_req, 0);
    check_output("bp_valid", instr_valid, 1);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 32'h0);
    check_output("bp_one_pop_no_req", mem_req, 0);
    check_output("bp_one_pop_acks", acks, 2);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    check_output("bp_two_pop_req", mem_req, 1);

    // Zero-wait memory with decode always ready delivers one halfword per cycle.
    $display("[TB] throughput sequence");
    do_reset();
    lat_fixed = 0;
    apply_stimulus(1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    base = consumed;
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, 32'h0);
    check_output("throughput_20", consumed - base, 20);

    // Slow memory with a redirect during the wait: address held, data dropped.
    $display("[TB] redirect during wait sequence");
    do_reset();
    lat_fixed = 3;
    apply_stimulus(1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b1, 32'h40);
    check_output("drop_mem_req", mem_req, 1);
    check_output("drop_mem_addr", mem_addr, 0);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    check_output("drop_then_idle", mem_req, 0);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    check_output("refetch_mem_req", mem_req, 1);
    check_output("refetch_mem_addr", mem_addr, 16);
    base = consumed;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0);
      if (consumed > base) done = 1;
    end
    if (!done) report_timeout("drop_first_instr");

    // Ack, pop and redirect all in the same cycle.
    $display("[TB] simultaneous ack/pop/redirect sequence");
    do_reset();
    lat_fixed = 0;
    apply_stimulus(1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    check_output("simul_pre_valid", instr_valid, 1);
    check_output("simul_pre_req", mem_req, 1);
    apply_stimulus(1'b1, 1'b1, 32'h100);
    base = consumed;
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 32'h0);
    check_output("simul_progress", (consumed - base) >= 4, 1);

    // Fetch PC wraps from the top of the address space to zero.
    $display("[TB] wraparound sequence");
    do_reset();
    lat_fixed = 1;
    apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    base = consumed;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0);
      if (consumed - base >= 3) done = 1;
    end
    if (!done) report_timeout("wrap_three_instrs");
    check_output("wrap_first_addr", (req_log.size() > 0) ? req_log[0] : 10'h155, 10'h3FF);
    check_output("wrap_second_addr", (req_log.size() > 1) ? req_log[1] : 10'h155, 10'h000);

    // Reset asserted while a request is outstanding.
    $display("[TB] reset mid-request sequence");
    do_reset();
    lat_fixed = 3;
    apply_stimulus(1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    check_output("midreset_req_before", mem_req, 1);
    do_reset();

    // Randomised traffic against the scoreboard.
    $display("[TB] random sequence");
    lat_fixed = -1;
    base  = consumed;
    last  = consumed;
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 39) == 0);
      rpc   = $urandom;
      apply_stimulus(rdy, redir, rpc);
      if (consumed != last) begin
        last  = consumed;
        stall = 0;
      end else begin
        stall++;
        if (stall > 60) begin
          report_timeout("random_progress");
          stall = 0;
        end
      end
    end
    check_output("random_volume", (consumed - base) >= 500, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/thumb_fetch_unit.md
# thumb_fetch_unit

Instruction fetch and prefetch stage that sits directly upstream of the instruction decoder. It issues 32-bit word reads to instruction memory and splits each returned word into 16-bit Thumb halfwords. The halfwords go into a small prefetch FIFO and are presented to decode over a valid/ready handshake, each tagged with its byte address. It also absorbs branch redirects from execute by flushing and refetching.

## Interface
- DEPTH, 4, halfword FIFO entries; power of two, ≥2
- RESET_PC, 32'h0, byte address fetched first after reset
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous and active-low
- mem_req  out  1  word read request; held until mem_ack
- mem_addr  out  10  word address = fetch_pc[11:2]; stable while mem_req high
- mem_ack  in  1  read complete this cycle; mem_rdata valid
- mem_rdata  in  32  returned word; halfword 0 = [15:0], halfword 1 = [31:16]
- redirect  in  1  branch taken; flush and refetch
- redirect_pc  in  32  new byte PC; bit 0 ignored (forced 0)
- instr_valid  out  1  FIFO head valid
- instr  out  16  FIFO head halfword
- instr_pc  out  32  byte address of instr (not PC+4; decode adds 4)
- instr_ready  in  1  decode consumes head when instr_valid && instr_ready

## Operation
- fetch_pc: 32-bit byte address, halfword aligned, wraps modulo 2^32; memory aliasing via mem_addr = fetch_pc[11:2]
- FSM states: IDLE (mem_req=0), FETCH (mem_req=1), DROP (mem_req=1, data discarded)
- IDLE→FETCH when free slots (DEPTH − count) ≥ 2 and no redirect
- FETCH on mem_ack: push halfwords, fetch_pc += (fetch_pc[1] ? 2 : 4); →FETCH if free after push/pop ≥ 2, else →IDLE
- Push on ack: fetch_pc[1]=0 → push [15:0] (pc) then [31:16] (pc+2); fetch_pc[1]=1 → push [31:16] only (pc)
- redirect (any state): FIFO cleared, fetch_pc ← {redirect_pc[31:1],1'b0}; FETCH without ack →DROP; FETCH with ack same cycle → data discarded, →IDLE; IDLE→IDLE
- DROP: hold mem_req and old mem_addr until mem_ack, discard data, →IDLE; a further redirect in DROP only updates fetch_pc
- Redirect has priority over push and pop in the same cycle; the popped head is still considered consumed by decode
- Simultaneous push and pop: count ← count + pushed − popped; the free check for a new request uses the post-update count
- Empty: instr_valid=0, instr/instr_pc hold the last head storage value
- Full: no request issued; never overflows, because a request needs ≥2 free

## Timing
- Reset values: state IDLE, fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC[11:2], instr_valid=0, instr=0, instr_pc=0, count=0
- Reset asserted mid-request: immediate return to reset values; the outstanding request is abandoned (memory must tolerate this)
- First mem_req is high in the first cycle after reset release
- mem_ack may arrive in the same cycle mem_req rises (zero-wait memory)
- Ack at edge N → instr_valid high in cycle N+1 (registered FIFO, combinational head)
- Zero-wait memory with decode always ready: sustained 1 halfword/cycle with DEPTH=4
- Redirect at edge N → instr_valid=0 in cycle N+1; next mem_req for redirect_pc no earlier than cycle N+1

## Structure
- Package thumb_fetch_pkg: FSM state enum (IDLE/FETCH/DROP), HWORD_W=16, WORD_W=32, MEM_AWIDTH=10
- Sub-module fetch_hw_fifo: DEPTH-entry {pc,halfword} FIFO with 0/1/2-entry push, 1-entry pop and synchronous flush; exports count
- Top: FSM, fetch_pc and halfword split logic

## Test plan
- Reset, zero-wait memory, word0=32'hBEEF_2005, instr_ready=1 → instr 16'h2005 @pc 0, then 16'hBEEF @pc 2 on consecutive cycles
- redirect_pc=32'h0000_0007 → mem_addr=1, only mem_rdata[31:16] pushed, instr_pc=6, next mem_addr=2
- instr_ready=0 with zero-wait memory → exactly 2 requests complete, count=4, mem_req low; one pop does not restart, two pops restart
- 3-cycle ack latency, redirect to 32'h40 in cycle 1 of the wait → mem_req held on old addr, returned data dropped, then mem_addr=16, first instr_pc=32'h40
- Simultaneous ack, pop and redirect → FIFO empty next cycle, no stale halfword ever shows instr_valid
- fetch_pc=32'hFFFF_FFFC → instr_pc FFFF_FFFC, FFFF_FFFE, then 0000_0000 with mem_addr=0
